vc_skid_queue: RTL and testbench

- Two-entry valid/ready skid queue that decouples a producer from a downstream register stage.
- Typically placed directly upstream of an enable register, with deq_val/deq_rdy driving that register's en.
- enq_rdy comes from state only: no combinational path from deq_rdy to enq_rdy.
- Full throughput: one message per cycle sustained when the consumer is always ready.

---
 rtl/vc_skid_queue.sv | 70 +++++++
 tb/tb_vc_skid_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vc_skid_queue.sv
// Two-entry valid/ready skid queue; enq_rdy is derived from state only.
// Define VC_SKID_QUEUE_BYPASS_EN for a zero-latency pass-through when empty.
module vc_skid_queue #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic [1:0]         num_free
);

  logic [1:0]         count;
  logic               wr_ptr;
  logic               rd_ptr;
  logic [p_nbits-1:0] entry [2];

  logic enq_fire;
  logic deq_fire;
  logic pass;
  logic do_wr;
  logic do_rd;

  // Gated by reset so the producer sees "not ready" while reset is held.
  assign enq_rdy  = reset && (count != 2'd2);
  assign num_free = 2'd2 - count;

`ifdef VC_SKID_QUEUE_BYPASS_EN
  assign deq_val = reset && ((count != 2'd0) || enq_val);
  assign deq_msg = (count == 2'd0) ? enq_msg : entry[rd_ptr];
  assign pass    = (count == 2'd0) && enq_fire && deq_rdy;
`else
  assign deq_val = (count != 2'd0);
  assign deq_msg = entry[rd_ptr];
  assign pass    = 1'b0;
`endif

  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;
  // A passed-through message never touches storage, pointers or count.
  assign do_wr    = enq_fire && !pass;
  assign do_rd    = deq_fire && !pass;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= ~wr_ptr;
      if (do_rd) rd_ptr <= ~rd_ptr;
      if (do_wr && !do_rd)      count <= count + 2'd1;
      else if (!do_wr && do_rd) count <= count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) entry[wr_ptr] <= enq_msg;
  end

`ifndef SYNTHESIS
  a_enq_val_known: assert property (@(posedge clk) disable iff (!reset) !$isunknown(enq_val));
  a_deq_rdy_known: assert property (@(posedge clk) disable iff (!reset) !$isunknown(deq_rdy));
`endif

endmodule

// File: tb/tb_vc_skid_queue.sv
// Randomized bench for vc_skid_queue against a queue-based reference model.
module tb_vc_skid_queue;
  localparam int W = 32;
`ifdef VC_SKID_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enq_val = 1'b0;
  logic         enq_rdy;
  logic [W-1:0] enq_msg = '0;
  logic         deq_val;
  logic         deq_rdy = 1'b0;
  logic [W-1:0] deq_msg;
  logic [1:0]   num_free;

  vc_skid_queue #(.p_nbits(W)) dut (
    .clk(clk), .reset(reset),
    .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_msg(enq_msg),
    .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_msg(deq_msg),
    .num_free(num_free)
  );

  always #5 clk = ~clk;

  logic [W-1:0] q[$];
  int n_checks = 0;
  int n_bad = 0;
  int n_deq = 0;
  bit last_enq_fire = 1'b0;

  function automatic bit m_enq_rdy();
    return reset && (q.size() < 2);
  endfunction
  function automatic bit m_deq_val();
    return reset && ((q.size() != 0) || (BYP && enq_val));
  endfunction
  function automatic logic [W-1:0] m_deq_msg();
    return (q.size() != 0) ? q[0] : enq_msg;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: enqueue first, then pop, so an empty bypass transfer nets to nothing.
  always @(posedge clk) begin
    bit ef, df;
    if (reset) begin
      ef = enq_val && m_enq_rdy();
      df = m_deq_val() && deq_rdy;
      if (ef) q.push_back(enq_msg);
      if (df) void'(q.pop_front());
      last_enq_fire = ef;
    end else begin
      last_enq_fire = 1'b0;
    end
  end

  always @(negedge reset) q.delete();

  always @(negedge clk) begin
    #2;
    chk("enq_rdy", {31'd0, enq_rdy}, {31'd0, m_enq_rdy()});
    chk("deq_val", {31'd0, deq_val}, {31'd0, m_deq_val()});
    chk("num_free", {30'd0, num_free}, 32'(2 - q.size()));
    if (m_deq_val()) chk("deq_msg", deq_msg, m_deq_msg());
    if (deq_val && deq_rdy) n_deq++;
  end

  initial begin
    int sent;
    int cyc;
    void'($urandom(32'd12345));

    // Reset held with enq_val asserted
    enq_val = 1'b1;
    enq_msg = 32'h55;
    repeat (3) begin
      @(negedge clk);
      #3;
      chk("rst_enq_rdy", {31'd0, enq_rdy}, 32'd0);
      chk("rst_deq_val", {31'd0, deq_val}, 32'd0);
      chk("rst_num_free", {30'd0, num_free}, 32'd2);
    end
    @(negedge clk);
    reset = 1'b1;
    enq_val = 1'b0;
    #3;
    chk("rel_enq_rdy", {31'd0, enq_rdy}, 32'd1);

    // Fill with deq_rdy low, then drain
    @(negedge clk); enq_val = 1'b1; enq_msg = 32'hA5; deq_rdy = 1'b0;
    #3; chk("fill_free0", {30'd0, num_free}, 32'd2);
    @(negedge clk); enq_msg = 32'h3C;
    #3; chk("fill_free1", {30'd0, num_free}, 32'd1);
    chk("fill_head1", deq_msg, 32'hA5);
    @(negedge clk); enq_val = 1'b0;
    #3; chk("fill_free2", {30'd0, num_free}, 32'd0);
    chk("fill_rdy", {31'd0, enq_rdy}, 32'd0);
    chk("fill_head2", deq_msg, 32'hA5);
    @(negedge clk); deq_rdy = 1'b1;
    #3; chk("drain_a5", deq_msg, 32'hA5);
    @(negedge clk);
    #3; chk("drain_3c", deq_msg, 32'h3C);
    @(negedge clk); deq_rdy = 1'b0;
    #3; chk("drain_empty", {31'd0, deq_val}, 32'd0);

    // Streaming
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); enq_val = 1'b1; enq_msg = i; deq_rdy = 1'b1;
      #3;
      if (i >= 1) begin
        chk("stream_free", {30'd0, num_free}, BYP ? 32'd2 : 32'd1);
        chk("stream_msg", deq_msg, BYP ? 32'(i) : 32'(i - 1));
      end
    end
    @(negedge clk); enq_val = 1'b0;
    @(negedge clk); deq_rdy = 1'b0;
    @(negedge clk);

    // Random val/rdy with producer hold obligation
    n_deq = 0;
    sent = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (last_enq_fire) sent++;
      if (!(enq_val && !last_enq_fire)) begin
        enq_val = (sent < 1000) && ($urandom_range(0, 99) < 60);
        enq_msg = 32'h1000 + sent;
      end
      deq_rdy = ($urandom_range(0, 99) < 55);
      if (sent == 1000 && !enq_val && q.size() == 0) break;
      cyc++;
      if (cyc > 20000) begin
        n_checks++;
        n_bad++;
        $display("FAIL rand_timeout: sent %0d of 1000", sent);
        break;
      end
    end
    deq_rdy = 1'b0;
    enq_val = 1'b0;
    #3; chk("rand_count", n_deq, 32'd1000);

    // Asynchronous reset pulse mid-cycle with a full queue
    @(negedge clk); enq_val = 1'b1; enq_msg = 32'h11;
    @(negedge clk); enq_msg = 32'h22;
    @(negedge clk); enq_val = 1'b0;
    #3; chk("full_free", {30'd0, num_free}, 32'd0);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("arst_deq_val", {31'd0, deq_val}, 32'd0);
    chk("arst_free", {30'd0, num_free}, 32'd2);
    #1 reset = 1'b1;
    @(negedge clk); enq_val = 1'b1; enq_msg = 32'h33;
    @(negedge clk); enq_val = 1'b0;
    #3;
    chk("post_rst_val", {31'd0, deq_val}, 32'd1);
    chk("post_rst_msg", deq_msg, 32'h33);
    @(negedge clk); deq_rdy = 1'b1;
    @(negedge clk); deq_rdy = 1'b0;

    // Empty queue, enq and deq offered together
    @(negedge clk); enq_val = 1'b1; enq_msg = 32'h7E; deq_rdy = 1'b1;
    #3;
    if (BYP) begin
      chk("byp_val", {31'd0, deq_val}, 32'd1);
      chk("byp_msg", deq_msg, 32'h7E);
      chk("byp_free", {30'd0, num_free}, 32'd2);
    end else begin
      chk("nobyp_val", {31'd0, deq_val}, 32'd0);
    end
    @(negedge clk); enq_val = 1'b0; deq_rdy = 1'b0;
    #3;
    if (BYP) begin
      chk("byp_after_val", {31'd0, deq_val}, 32'd0);
      chk("byp_after_free", {30'd0, num_free}, 32'd2);
    end else begin
      chk("nobyp_after_val", {31'd0, deq_val}, 32'd1);
      chk("nobyp_after_msg", deq_msg, 32'h7E);
      chk("nobyp_after_free", {30'd0, num_free}, 32'd1);
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
